// File: rtl/allocator_pkg.sv
// Shared definitions for the output-channel allocator: flit-type codes,
// FSM state encoding and flit classification helpers.
package allocator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] FLIT_HEAD   = 2'b10;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b01;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  function automatic logic is_head(input logic [1:0] f);
    return (f == FLIT_HEAD) || (f == FLIT_SINGLE);
  endfunction

  function automatic logic is_tail(input logic [1:0] f);
    return (f == FLIT_TAIL) || (f == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/allocator_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr_i and wraps, first requester wins.
module rr_arbiter #(
  parameter int N = 5,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [SW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [SW:0] w_pos;
  logic        w_found;

  // Scan requests from the pointer position, wrapping modulo N.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    w_found   = 1'b0;
    w_pos     = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, ptr_i} + (SW+1)'(k);
      if (w_pos >= (SW+1)'(N)) begin
        w_pos = w_pos - (SW+1)'(N);
      end else begin
        w_pos = w_pos;
      end
      if (!w_found && req_i[w_pos[SW-1:0]]) begin
        w_found                 = 1'b1;
        gnt_o[w_pos[SW-1:0]]    = 1'b1;
        gnt_idx_o               = w_pos[SW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/allocator.sv
// Wormhole output-channel allocator: grants one input at a time via round-robin
// and holds ownership until the owner's tail (or single) flit transfers.
module allocator
  import allocator_pkg::*;
#(
  parameter int IN_N        = 5,
  parameter int OUT_M       = 5,
  parameter int FLIT_ID_W   = 2,
  parameter int HOP_CNT_W   = 4,
  parameter int OUT_CHAN_ID = 0,
  localparam int RW = (OUT_M > 1) ? $clog2(OUT_M) : 1,
  localparam int SW = (IN_N > 1) ? $clog2(IN_N) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [IN_N*RW-1:0]          rtr_res_i,
  input  logic [IN_N-1:0]             rtr_res_vld_i,
  input  logic [IN_N*HOP_CNT_W-1:0]   hop_count_i,
  input  logic [IN_N*FLIT_ID_W-1:0]   flit_id_i,
  input  logic [IN_N-1:0]             data_vld_i,
  input  logic                        forward_node_rdy_i,
  output logic [SW-1:0]               sel_o,
  output logic                        out_vld_o,
  output logic [IN_N-1:0]             chan_alloc_o
);

  state_t          r_state;
  logic [SW-1:0]   r_owner;
  logic [SW-1:0]   r_ptr;
  logic [IN_N-1:0] r_chan_alloc;

  logic [IN_N-1:0] w_req;
  logic [IN_N-1:0] w_gnt;
  logic [SW-1:0]   w_gnt_idx;
  logic            w_any;
  logic [SW-1:0]   w_ptr_nxt;
  logic [1:0]      w_owner_flit;
  logic            w_xfer;
  logic            w_unused_hop;

  assign w_unused_hop = ^hop_count_i;

  // An input requests only with a valid head-type flit routed to this output.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < IN_N; i++) begin
      if (data_vld_i[i] && rtr_res_vld_i[i] &&
          (rtr_res_i[i*RW +: RW] == RW'(OUT_CHAN_ID)) &&
          is_head(flit_id_i[i*FLIT_ID_W +: 2])) begin
        w_req[i] = 1'b1;
      end else begin
        w_req[i] = 1'b0;
      end
    end
  end

  rr_arbiter #(.N(IN_N)) u_arb (
    .req_i     (w_req),
    .ptr_i     (r_ptr),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx),
    .any_o     (w_any)
  );

  assign w_ptr_nxt    = (w_gnt_idx == SW'(IN_N-1)) ? SW'(0) : (w_gnt_idx + SW'(1));
  assign w_owner_flit = flit_id_i[r_owner*FLIT_ID_W +: 2];
  assign w_xfer       = (r_state == ST_BUSY) && data_vld_i[r_owner] && forward_node_rdy_i;

  // Ownership FSM; the grant is taken only from IDLE, so release and re-grant never share a cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_ptr        <= '0;
      r_chan_alloc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state      <= ST_BUSY;
            r_owner      <= w_gnt_idx;
            r_ptr        <= w_ptr_nxt;
            r_chan_alloc <= w_gnt;
          end
        end
        ST_BUSY: begin
          if (w_xfer && is_tail(w_owner_flit)) begin
            r_state      <= ST_IDLE;
            r_chan_alloc <= '0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_chan_alloc <= '0;
        end
      endcase
    end
  end

  assign sel_o        = r_owner;
  assign chan_alloc_o = r_chan_alloc;
  assign out_vld_o    = w_xfer;

endmodule

// File: tb/tb_allocator.sv
// Directed bench: stimulus pushes expected transfers (owner index) into a queue,
// a negedge monitor pops and checks sel_o/chan_alloc_o on every out_vld_o.
module tb_allocator;

  localparam int IN_N = 5;
  localparam int RW   = 3;
  localparam int SW   = 3;

  localparam logic [1:0] HEAD   = 2'b10;
  localparam logic [1:0] BODY   = 2'b00;
  localparam logic [1:0] TAIL   = 2'b01;
  localparam logic [1:0] SINGLE = 2'b11;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [IN_N*RW-1:0] rtr_res_i;
  logic [IN_N-1:0]   rtr_res_vld_i;
  logic [IN_N*4-1:0] hop_count_i;
  logic [IN_N*2-1:0] flit_id_i;
  logic [IN_N-1:0]   data_vld_i;
  logic              forward_node_rdy_i;
  logic [SW-1:0]     sel_o;
  logic              out_vld_o;
  logic [IN_N-1:0]   chan_alloc_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  allocator dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .rtr_res_i          (rtr_res_i),
    .rtr_res_vld_i      (rtr_res_vld_i),
    .hop_count_i        (hop_count_i),
    .flit_id_i          (flit_id_i),
    .data_vld_i         (data_vld_i),
    .forward_node_rdy_i (forward_node_rdy_i),
    .sel_o              (sel_o),
    .out_vld_o          (out_vld_o),
    .chan_alloc_o       (chan_alloc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int i, input bit v, input logic [RW-1:0] r, input logic [1:0] f);
    data_vld_i[i]          = v;
    rtr_res_vld_i[i]       = v;
    rtr_res_i[i*RW +: RW]  = r;
    flit_id_i[i*2 +: 2]    = f;
  endtask

  task automatic clear_all();
    data_vld_i    = '0;
    rtr_res_vld_i = '0;
    rtr_res_i     = '0;
    flit_id_i     = '0;
  endtask

  // One clock cycle with the current inputs; xfer says whether owner s must transfer.
  task automatic cycle(input bit xfer, input int s);
    if (xfer) exp_q.push_back(s);
    #3;
    chk("out_vld", {31'd0, out_vld_o}, {31'd0, xfer});
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_all();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Monitor: every transfer must match the next expected owner.
  always @(negedge clk_i) begin
    if (out_vld_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer actual sel=%0d expected none at %0t", sel_o, $time);
      end else begin
        int s;
        logic [IN_N-1:0] oh;
        s  = exp_q.pop_front();
        oh = 5'b00001 << s;
        chk("xfer_sel", {29'd0, sel_o}, s);
        chk("xfer_chan_alloc", {27'd0, chan_alloc_o}, {27'd0, oh});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    hop_count_i        = '0;
    forward_node_rdy_i = 1'b1;
    do_reset();
    chk("rst_sel", {29'd0, sel_o}, 32'd0);
    chk("rst_out_vld", {31'd0, out_vld_o}, 32'd0);
    chk("rst_chan_alloc", {27'd0, chan_alloc_o}, 32'd0);

    // Single requester: input 2, HEAD then TAIL.
    set_in(2, 1'b1, 3'd0, HEAD);
    cycle(1'b0, 0);
    chk("t1_chan", {27'd0, chan_alloc_o}, 32'b00100);
    chk("t1_sel", {29'd0, sel_o}, 32'd2);
    cycle(1'b1, 2);
    set_in(2, 1'b1, 3'd0, TAIL);
    cycle(1'b1, 2);
    clear_all();
    chk("t1_idle_chan", {27'd0, chan_alloc_o}, 32'd0);
    chk("t1_idle_sel_hold", {29'd0, sel_o}, 32'd2);
    cycle(1'b0, 0);

    // Simultaneous requests 1 and 3 from pointer 0.
    do_reset();
    set_in(1, 1'b1, 3'd0, HEAD);
    set_in(3, 1'b1, 3'd0, HEAD);
    cycle(1'b0, 0);
    chk("t2_first_chan", {27'd0, chan_alloc_o}, 32'b00010);
    set_in(1, 1'b1, 3'd0, TAIL);
    cycle(1'b1, 1);
    set_in(1, 1'b0, 3'd0, BODY);
    chk("t2_gap_chan", {27'd0, chan_alloc_o}, 32'd0);
    cycle(1'b0, 0);
    chk("t2_second_chan", {27'd0, chan_alloc_o}, 32'b01000);
    cycle(1'b1, 3);
    set_in(3, 1'b1, 3'd0, TAIL);
    cycle(1'b1, 3);
    clear_all();
    chk("t2_end_chan", {27'd0, chan_alloc_o}, 32'd0);
    cycle(1'b0, 0);

    // Four-flit packet on input 0 with a 3-cycle downstream stall (pointer at 4).
    set_in(0, 1'b1, 3'd0, HEAD);
    cycle(1'b0, 0);
    cycle(1'b1, 0);
    set_in(0, 1'b1, 3'd0, BODY);
    cycle(1'b1, 0);
    forward_node_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_stall_chan", {27'd0, chan_alloc_o}, 32'b00001);
      cycle(1'b0, 0);
    end
    forward_node_rdy_i = 1'b1;
    cycle(1'b1, 0);
    set_in(0, 1'b1, 3'd0, TAIL);
    cycle(1'b1, 0);
    clear_all();
    chk("t3_end_chan", {27'd0, chan_alloc_o}, 32'd0);
    cycle(1'b0, 0);

    // Wrong route gives no grant; then a SINGLE flit on input 0.
    set_in(4, 1'b1, 3'd3, HEAD);
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    chk("t4_no_grant_chan", {27'd0, chan_alloc_o}, 32'd0);
    clear_all();
    set_in(0, 1'b1, 3'd0, SINGLE);
    cycle(1'b0, 0);
    cycle(1'b1, 0);
    clear_all();
    chk("t4_single_release", {27'd0, chan_alloc_o}, 32'd0);
    cycle(1'b0, 0);

    // Grant 4 wraps the pointer, then 0 beats 4; reset aborts mid-packet.
    set_in(4, 1'b1, 3'd0, SINGLE);
    cycle(1'b0, 0);
    cycle(1'b1, 4);
    set_in(4, 1'b1, 3'd0, HEAD);
    set_in(0, 1'b1, 3'd0, HEAD);
    chk("t5_gap_chan", {27'd0, chan_alloc_o}, 32'd0);
    cycle(1'b0, 0);
    chk("t5_wrap_chan", {27'd0, chan_alloc_o}, 32'b00001);
    cycle(1'b1, 0);
    set_in(0, 1'b1, 3'd0, BODY);
    forward_node_rdy_i = 1'b0;
    rst_i = 1'b1;
    cycle(1'b0, 0);
    rst_i = 1'b0;
    forward_node_rdy_i = 1'b1;
    chk("t5_rst_sel", {29'd0, sel_o}, 32'd0);
    chk("t5_rst_chan", {27'd0, chan_alloc_o}, 32'd0);
    cycle(1'b0, 0);
    clear_all();
    cycle(1'b0, 0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/allocator.md
ALLOCATOR -- requirements
Module: allocator

Interface
REQ-001 Parameter IN_N, default 5, number of input channels competing for this output.
REQ-002 Parameter OUT_M, default 5, number of router outputs; route field width RW = clog2(OUT_M).
REQ-003 Parameter FLIT_ID_W, default 2, flit-type field width per input.
REQ-004 Parameter HOP_CNT_W, default 4, hop-count field width per input.
REQ-005 Parameter OUT_CHAN_ID, default 0, index of the output channel this allocator owns.
REQ-006 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_i  input  1  synchronous, active-high reset.
REQ-008 rtr_res_i  input  IN_N*RW  routing result per input; field i = bits [i*RW +: RW].
REQ-009 rtr_res_vld_i  input  IN_N  routing result valid per input.
REQ-010 hop_count_i  input  IN_N*HOP_CNT_W  per-input hop count; reserved, ignored by logic.
REQ-011 flit_id_i  input  IN_N*FLIT_ID_W  flit type of head-of-queue flit per input.
REQ-012 data_vld_i  input  IN_N  head-of-queue flit valid per input.
REQ-013 forward_node_rdy_i  input  1  downstream node can accept a flit this cycle.
REQ-014 sel_o  output  clog2(IN_N)  index of input currently owning the output (crossbar select).
REQ-015 out_vld_o  output  1  a flit transfers from input sel_o to the output this cycle.
REQ-016 chan_alloc_o  output  IN_N  one-hot ownership vector to the input VCs.

Function
REQ-017 Flit types: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE(head+tail)=2'b11.
REQ-018 Input i requests when data_vld_i[i] & rtr_res_vld_i[i] & rtr_res field i == OUT_CHAN_ID & flit type is HEAD or SINGLE.
REQ-019 Two states: IDLE (output free) and BUSY (output owned by one input, register owner).
REQ-020 In IDLE with >=1 request, a round-robin arbiter picks one requester; next cycle state=BUSY, owner=winner, RR pointer = winner+1 (mod IN_N).
REQ-021 RR priority starts at the pointer and wraps; after reset input 0 has highest priority.
REQ-022 In IDLE with no request, state stays IDLE; out_vld_o=0, chan_alloc_o=0, sel_o holds last owner.
REQ-023 In BUSY: chan_alloc_o = one-hot(owner), sel_o = owner; requests from other inputs are ignored.
REQ-024 out_vld_o = BUSY & data_vld_i[owner] & forward_node_rdy_i (combinational); the owning VC pops on out_vld_o.
REQ-025 If BUSY and owner data invalid or forward_node_rdy_i=0, no transfer; ownership held (wormhole stall).
REQ-026 On a transfer whose flit type is TAIL or SINGLE, state returns to IDLE next cycle; no new grant that same cycle.
REQ-027 Grant-to-first-transfer latency is 1 cycle; minimum gap between packets on this output is 1 idle cycle.
REQ-028 HEAD/BODY flits of the owner never release; flit type of non-owners never affects state.

Reset
REQ-029 On rst_i=1 at a clock edge: state=IDLE, owner=0, RR pointer=0; sel_o=0, out_vld_o=0, chan_alloc_o=0 from the following cycle.
REQ-030 Reset mid-packet aborts ownership immediately; no partial-packet recovery.

Structure
REQ-031 Shared package holds flit-type constants (HEAD/BODY/TAIL/SINGLE) and state encoding.
REQ-032 One sub-module rr_arbiter (IN_N requests, pointer in, one-hot grant + index out) is used; remainder is the FSM/owner register.

Verification
REQ-033 After reset, input 2 HEAD to port 0, rdy=1 -> next cycle chan_alloc_o=00100, sel_o=2, out_vld_o=1.
REQ-034 Inputs 1 and 3 request simultaneously, pointer 0 -> input 1 wins; after its TAIL, input 3 granted after one IDLE cycle.
REQ-035 Owner sends HEAD, BODY, BODY, TAIL with rdy=1 -> out_vld_o high 4 cycles, then IDLE, chan_alloc_o=0.
REQ-036 rdy=0 for 3 cycles mid-packet -> out_vld_o=0, chan_alloc_o unchanged, resumes when rdy=1.
REQ-037 Input 4 HEAD with rtr_res=3 (OUT_CHAN_ID=0) -> no grant; SINGLE flit on input 0 -> 1 transfer then IDLE.
REQ-038 Grant input 4, pointer wraps -> next contest between inputs 0 and 4 won by input 0; rst_i mid-packet -> all outputs 0.
